// File: rtl/sid_audio_i2s.sv
// SID output stage: per-chip first-order IIR smoothing (chip 0 left, chip 1 right)
// feeding a free-running 24-bit I2S transmitter with 64 BCLK per frame.
module sid_audio_i2s #(
  parameter int BCLK_HALF = 4,
  parameter int SHIFT     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [19:0] audio_i,
  input  logic               valid_i,
  input  logic               chan_i,
  output logic               bclk_o,
  output logic               lrclk_o,
  output logic               sdata_o
);

  localparam int CNT_W = $clog2(BCLK_HALF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCLK_HALF - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bclk_q, bclk_d;
  logic [5:0]         bit_idx_q, bit_idx_d;
  logic [5:0]         bit_nxt;
  logic               lrclk_q, lrclk_d;
  logic               sdata_q, sdata_d;
  logic signed [23:0] acc_l_q, acc_l_d;
  logic signed [23:0] acc_r_q, acc_r_d;
  logic signed [23:0] snap_l_q, snap_l_d;
  logic signed [23:0] snap_r_q, snap_r_d;

  // acc + (x24 - acc) >>> SHIFT; the floored step never overshoots x24, so no clamp.
  function automatic logic signed [23:0] iir_step(input logic signed [23:0] acc,
                                                  input logic signed [19:0] x);
    logic signed [23:0] x24;
    logic signed [24:0] diff;
    logic signed [24:0] step;
    x24  = {x, 4'b0000};
    diff = {x24[23], x24} - {acc[23], acc};
    step = diff >>> SHIFT;
    return acc + step[23:0];
  endfunction

  // Slot 0 is the I2S one-bit MSB delay; slots 25..31 pad the 32-bit half-frame.
  function automatic logic slot_bit(input logic [4:0]  slot,
                                    input logic [23:0] word);
    logic [4:0] idx;
    idx = 5'd24 - slot;
    if (slot == 5'd0 || slot > 5'd24) return 1'b0;
    return word[idx];
  endfunction

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    bclk_d    = bclk_q;
    bit_idx_d = bit_idx_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    snap_l_d  = snap_l_q;
    snap_r_d  = snap_r_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    bit_nxt   = bit_idx_q + 6'd1;

    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      bclk_d = ~bclk_q;
      if (bclk_q) begin
        bit_idx_d = bit_nxt;
        lrclk_d   = bit_nxt[5];
        sdata_d   = slot_bit(bit_nxt[4:0], bit_nxt[5] ? snap_r_q : snap_l_q);
        // Both channels latched together so a frame never mixes old and new data.
        if (bit_nxt == 6'd0) begin
          snap_l_d = acc_l_q;
          snap_r_d = acc_r_q;
        end
      end
    end

    if (valid_i) begin
      if (chan_i) acc_r_d = iir_step(acc_r_q, audio_i);
      else        acc_l_d = iir_step(acc_l_q, audio_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      bclk_q    <= 1'b0;
      bit_idx_q <= 6'd63;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      snap_l_q  <= '0;
      snap_r_q  <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      bclk_q    <= bclk_d;
      bit_idx_q <= bit_idx_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      snap_l_q  <= snap_l_d;
      snap_r_q  <= snap_r_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
    end
  end

  assign bclk_o  = bclk_q;
  assign lrclk_o = lrclk_q;
  assign sdata_o = sdata_q;

endmodule
